// File: rtl/predictor_access_arb.sv
// ============================================================================
// Module   : predictor_access_arb
// Purpose  : Shares the single branch-predictor table port between fetch
//            lookups and buffered execute-stage updates; runs clear sweeps.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module predictor_access_arb #(
    parameter int ENTRY_NUM  = 256,
    parameter int ADDR_WIDTH = $clog2(ENTRY_NUM),
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                          cpu_clk,
    input  logic                          cpu_rstn,
    input  logic                          lookup_req,
    input  logic [ADDR_WIDTH-1:0]         lookup_addr,
    output logic                          lookup_gnt,
    input  logic                          upd_valid,
    input  logic [ADDR_WIDTH-1:0]         upd_addr,
    input  logic                          upd_taken,
    output logic                          upd_ready,
    input  logic                          clr_req,
    output logic                          clr_busy,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic                          ram_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = (STARVE_LIM > 2) ? $clog2(STARVE_LIM) : 1;

    localparam logic [CNT_W-1:0]      c_full_cnt   = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0]      c_starve_max = STV_W'(STARVE_LIM - 1);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr  = ADDR_WIDTH'(ENTRY_NUM - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_fifo_addr  [FIFO_DEPTH];
    logic                    r_fifo_taken [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_fifo_cnt;
    logic [STV_W-1:0]        r_starve_cnt;
    logic [ADDR_WIDTH-1:0]   r_clr_ptr;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_starved;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_clr_start;
    logic                    w_clr_last;
    logic [ADDR_WIDTH-1:0]   w_head_addr;
    logic                    w_head_taken;

    assign w_full       = (r_fifo_cnt == c_full_cnt);
    assign w_empty      = (r_fifo_cnt == '0);
    assign w_starved    = (r_starve_cnt == c_starve_max);
    assign w_head_addr  = r_fifo_addr[r_rd_ptr];
    assign w_head_taken = r_fifo_taken[r_rd_ptr];
    assign w_clr_start  = (r_state == ST_RUN) && clr_req;
    assign w_clr_last   = (r_clr_ptr == c_last_addr);

    assign upd_ready = !w_full;
    assign w_push    = upd_valid && !w_full;
    assign clr_busy  = (r_state == ST_CLEAR);
    assign fifo_cnt  = r_fifo_cnt;

    // Arbitration and next-state; the first matching RUN rule wins.
    always_comb begin
        w_state_nxt = r_state;
        lookup_gnt  = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end
                if (w_full || (w_starved && !w_empty)) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = w_head_addr;
                    ram_wdata = w_head_taken;
                    w_pop     = 1'b1;
                end else if (lookup_req) begin
                    ram_en     = 1'b1;
                    ram_addr   = lookup_addr;
                    lookup_gnt = 1'b1;
                end else if (!w_empty) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = w_head_addr;
                    ram_wdata = w_head_taken;
                    w_pop     = 1'b1;
                end
            end
            ST_CLEAR: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = r_clr_ptr;
                if (w_clr_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state   <= ST_RUN;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr_start || (r_state == ST_CLEAR && w_clr_last)) begin
                r_clr_ptr <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Starting a sweep flushes the queue, including a push in that same cycle.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else if (w_clr_start) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_starve_cnt <= '0;
        end else if (w_clr_start || w_pop || w_empty) begin
            r_starve_cnt <= '0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + STV_W'(1);
        end
    end

    // Queue storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge cpu_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= upd_addr;
            r_fifo_taken[r_wr_ptr] <= upd_taken;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_predictor_access_arb.sv
// ============================================================================
// Module   : tb_predictor_access_arb
// Purpose  : Directed self-checking bench for predictor_access_arb.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_predictor_access_arb;

    logic       cpu_clk;
    logic       cpu_rstn;
    logic       lookup_req;
    logic [7:0] lookup_addr;
    logic       lookup_gnt;
    logic       upd_valid;
    logic [7:0] upd_addr;
    logic       upd_taken;
    logic       upd_ready;
    logic       clr_req;
    logic       clr_busy;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic       ram_wdata;
    logic [2:0] fifo_cnt;

    int n_vec;
    int n_err;

    predictor_access_arb dut (
        .cpu_clk     (cpu_clk),
        .cpu_rstn    (cpu_rstn),
        .lookup_req  (lookup_req),
        .lookup_addr (lookup_addr),
        .lookup_gnt  (lookup_gnt),
        .upd_valid   (upd_valid),
        .upd_addr    (upd_addr),
        .upd_taken   (upd_taken),
        .upd_ready   (upd_ready),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .fifo_cnt    (fifo_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, need finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset();
        cpu_rstn = 1'b0;
        lookup_req = 1'b0; lookup_addr = '0;
        upd_valid = 1'b0; upd_addr = '0; upd_taken = 1'b0;
        clr_req = 1'b0;
        repeat (3) step();
        #2;
        n_vec++;
        if ({clr_busy, upd_ready, ram_en, ram_we, lookup_gnt} !== 5'b01000) begin
            n_err++;
            $display("FAIL reset_outputs: got busy/rdy/en/we/gnt=%b, need 01000",
                     {clr_busy, upd_ready, ram_en, ram_we, lookup_gnt});
        end
        n_vec++;
        if (fifo_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL reset_fifo_cnt: got %0d, need 0", fifo_cnt);
        end
        step();
        cpu_rstn = 1'b1;
        step();
    endtask

    task automatic test_single_update();
        upd_valid = 1'b1; upd_addr = 8'h12; upd_taken = 1'b1;
        #2;
        n_vec++;
        if (ram_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_no_bypass: got ram_en=%b, need 0", ram_en);
        end
        step();
        upd_valid = 1'b0;
        #2;
        n_vec++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, fifo_cnt} !== {1'b1, 1'b1, 8'h12, 1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL single_write: got en=%b we=%b addr=%h wd=%b cnt=%0d, need 1 1 12 1 1",
                     ram_en, ram_we, ram_addr, ram_wdata, fifo_cnt);
        end
        step();
        #2;
        n_vec++;
        if ({ram_en, fifo_cnt} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL single_drained: got en=%b cnt=%0d, need 0 0", ram_en, fifo_cnt);
        end
    endtask

    task automatic test_starvation();
        lookup_req = 1'b1; lookup_addr = 8'h33;
        upd_valid = 1'b1; upd_addr = 8'h44; upd_taken = 1'b0;
        #2;
        n_vec++;
        if (lookup_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL starve_push_cycle: got gnt=%b, need 1", lookup_gnt);
        end
        step();
        upd_valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            #2;
            n_vec++;
            if ({lookup_gnt, ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b0, 8'h33}) begin
                n_err++;
                $display("FAIL starve_lookup_%0d: got gnt=%b en=%b we=%b addr=%h, need 1 1 0 33",
                         i, lookup_gnt, ram_en, ram_we, ram_addr);
            end
            step();
        end
        #2;
        n_vec++;
        if ({lookup_gnt, ram_we, ram_addr, ram_wdata} !== {1'b0, 1'b1, 8'h44, 1'b0}) begin
            n_err++;
            $display("FAIL starve_forced_write: got gnt=%b we=%b addr=%h wd=%b, need 0 1 44 0",
                     lookup_gnt, ram_we, ram_addr, ram_wdata);
        end
        step();
        #2;
        n_vec++;
        if ({lookup_gnt, fifo_cnt} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL starve_resume: got gnt=%b cnt=%0d, need 1 0", lookup_gnt, fifo_cnt);
        end
    endtask

    task automatic test_full_drain();
        logic [7:0] a;
        lookup_req = 1'b1; lookup_addr = 8'h55;
        for (int i = 0; i < 4; i++) begin
            a = 8'h80 + 8'(i);
            upd_valid = 1'b1; upd_addr = a; upd_taken = a[0];
            #2;
            n_vec++;
            if ({upd_ready, lookup_gnt} !== 2'b11) begin
                n_err++;
                $display("FAIL fill_%0d: got rdy=%b gnt=%b, need 1 1", i, upd_ready, lookup_gnt);
            end
            step();
        end
        upd_valid = 1'b0;
        #2;
        n_vec++;
        if ({fifo_cnt, upd_ready, lookup_gnt, ram_we, ram_addr, ram_wdata} !==
            {3'd4, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0}) begin
            n_err++;
            $display("FAIL full_forced: got cnt=%0d rdy=%b gnt=%b we=%b addr=%h wd=%b, need 4 0 0 1 80 0",
                     fifo_cnt, upd_ready, lookup_gnt, ram_we, ram_addr, ram_wdata);
        end
        step();
        lookup_req = 1'b0;
        for (int i = 1; i < 4; i++) begin
            a = 8'h80 + 8'(i);
            #2;
            n_vec++;
            if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, a, a[0]}) begin
                n_err++;
                $display("FAIL drain_order_%0d: got en=%b we=%b addr=%h wd=%b, need 1 1 %h %b",
                         i, ram_en, ram_we, ram_addr, ram_wdata, a, a[0]);
            end
            step();
        end
        #2;
        n_vec++;
        if (fifo_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL drain_empty: got cnt=%0d, need 0", fifo_cnt);
        end
    endtask

    task automatic test_push_pop();
        lookup_req = 1'b1; lookup_addr = 8'h01;
        upd_valid = 1'b1; upd_addr = 8'hA0; upd_taken = 1'b1;
        step();
        upd_addr = 8'hA1; upd_taken = 1'b0;
        step();
        lookup_req = 1'b0;
        upd_addr = 8'hA2; upd_taken = 1'b1;
        #2;
        n_vec++;
        if ({fifo_cnt, ram_we, ram_addr, ram_wdata} !== {3'd2, 1'b1, 8'hA0, 1'b1}) begin
            n_err++;
            $display("FAIL pushpop_older: got cnt=%0d we=%b addr=%h wd=%b, need 2 1 a0 1",
                     fifo_cnt, ram_we, ram_addr, ram_wdata);
        end
        step();
        upd_valid = 1'b0;
        #2;
        n_vec++;
        if ({fifo_cnt, ram_addr, ram_wdata} !== {3'd2, 8'hA1, 1'b0}) begin
            n_err++;
            $display("FAIL pushpop_count: got cnt=%0d addr=%h wd=%b, need 2 a1 0",
                     fifo_cnt, ram_addr, ram_wdata);
        end
        step();
        #2;
        n_vec++;
        if ({fifo_cnt, ram_addr, ram_wdata} !== {3'd1, 8'hA2, 1'b1}) begin
            n_err++;
            $display("FAIL pushpop_last: got cnt=%0d addr=%h wd=%b, need 1 a2 1",
                     fifo_cnt, ram_addr, ram_wdata);
        end
        step();
    endtask

    task automatic test_clear();
        lookup_req = 1'b1; lookup_addr = 8'h20;
        for (int i = 0; i < 3; i++) begin
            upd_valid = 1'b1; upd_addr = 8'h10 + 8'(i); upd_taken = 1'b1;
            step();
        end
        clr_req = 1'b1;
        upd_addr = 8'h13;
        #2;
        n_vec++;
        if ({clr_busy, lookup_gnt, fifo_cnt} !== {1'b0, 1'b1, 3'd3}) begin
            n_err++;
            $display("FAIL clr_req_cycle: got busy=%b gnt=%b cnt=%0d, need 0 1 3",
                     clr_busy, lookup_gnt, fifo_cnt);
        end
        step();
        for (int i = 0; i < 256; i++) begin
            clr_req   = (i == 50);
            upd_valid = (i == 100);
            upd_addr  = 8'h5A;
            upd_taken = 1'b1;
            #2;
            n_vec++;
            if ({clr_busy, ram_en, ram_we, ram_addr, ram_wdata, lookup_gnt, upd_ready} !==
                {1'b1, 1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL sweep_%0d: got busy=%b en=%b we=%b addr=%h wd=%b gnt=%b rdy=%b, need 1 1 1 %h 0 0 1",
                         i, clr_busy, ram_en, ram_we, ram_addr, ram_wdata, lookup_gnt, upd_ready, 8'(i));
            end
            if (i == 0) begin
                n_vec++;
                if (fifo_cnt !== 3'd0) begin
                    n_err++;
                    $display("FAIL sweep_flush: got cnt=%0d, need 0", fifo_cnt);
                end
            end
            step();
        end
        clr_req = 1'b0; upd_valid = 1'b0;
        #2;
        n_vec++;
        if ({clr_busy, lookup_gnt, ram_we, ram_addr, ram_wdata, fifo_cnt} !==
            {1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL sweep_post_write: got busy=%b gnt=%b we=%b addr=%h wd=%b cnt=%0d, need 0 0 1 5a 1 1",
                     clr_busy, lookup_gnt, ram_we, ram_addr, ram_wdata, fifo_cnt);
        end
        step();
        #2;
        n_vec++;
        if ({lookup_gnt, ram_addr, fifo_cnt} !== {1'b1, 8'h20, 3'd0}) begin
            n_err++;
            $display("FAIL sweep_resume: got gnt=%b addr=%h cnt=%0d, need 1 20 0",
                     lookup_gnt, ram_addr, fifo_cnt);
        end
        lookup_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_clear();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            upd_valid = (i == 10); upd_addr = 8'h77; upd_taken = 1'b0;
            step();
        end
        upd_valid = 1'b0;
        #2;
        n_vec++;
        if ({clr_busy, ram_addr, fifo_cnt} !== {1'b1, 8'd100, 3'd1}) begin
            n_err++;
            $display("FAIL midclr_pre: got busy=%b addr=%0d cnt=%0d, need 1 100 1",
                     clr_busy, ram_addr, fifo_cnt);
        end
        cpu_rstn = 1'b0;
        #1;
        n_vec++;
        if ({clr_busy, fifo_cnt, ram_en} !== {1'b0, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL midclr_reset: got busy=%b cnt=%0d en=%b, need 0 0 0",
                     clr_busy, fifo_cnt, ram_en);
        end
        step();
        cpu_rstn = 1'b1;
        lookup_req = 1'b1; lookup_addr = 8'h3C;
        #2;
        n_vec++;
        if ({lookup_gnt, ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b0, 8'h3C}) begin
            n_err++;
            $display("FAIL midclr_lookup: got gnt=%b en=%b we=%b addr=%h, need 1 1 0 3c",
                     lookup_gnt, ram_en, ram_we, ram_addr);
        end
        step();
        lookup_req = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_update();
        test_starvation();
        test_full_drain();
        test_push_pop();
        test_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
